mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the five-stage pipeline: the EX/MEM latch, word-addressed data memory and branch resolution in one block. It captures the ALU result, zero flag, store data, control and destination at the end of EX. During MEM it performs the load or store, asserts the PC-source select for taken branches, and presents everything the MEM/WB latch needs.

## Interface
- `DEPTH`, 256: data-memory depth in 32-bit words; power of two, 4..1024.
- `AW`, log2(DEPTH): word-index width, derived, not overridden.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold the latch; MEM instruction repeats next cycle.
- `flush`  in  1  load a bubble instead of EX values.
- `ex_wb`  in  2  {regwrite, memtoreg}.
- `ex_m`  in  3  {branch, memread, memwrite}.
- `ex_npc`  in  32  branch target from EX.
- `ex_aluout`  in  32  ALU result: address or data.
- `ex_aluzero`  in  1  ALU zero flag.
- `ex_rdata2`  in  32  store data.
- `ex_dst`  in  5  destination register.
- `mem_wb`  out  2  latched {regwrite, memtoreg}; gated to 0 on misalignment.
- `mem_pcsrc`  out  1  branch & zero & valid.
- `mem_npc`  out  32  latched branch target.
- `mem_aluout`  out  32  latched ALU result.
- `mem_rdata`  out  32  load data.
- `mem_dst`  out  5  latched destination.
- `mem_misalign`  out  1  load/store with address[1:0] != 0.

## Operation
- Latch fields: valid, wb, m, npc, aluout, zero, rdata2, dst.
- Edge priority: rst > flush > stall > load.
  - rst: all fields 0, valid 0.
  - flush: valid 0, wb/m 0, data fields don't-care.
  - stall: hold every field.
  - Otherwise: capture ex_* and set valid 1.
- Memory array: DEPTH x 32, indexed by `mem_aluout[AW+1:2]`; upper address bits ignored, so addresses wrap modulo DEPTH*4.
- Array is not cleared by reset; it is zero-initialised in simulation.
- Misalignment: `mem_misalign` = valid & (memread | memwrite) & (mem_aluout[1:0] != 0).
  - A misaligned access performs no write.
  - `mem_rdata` is 0.
  - `mem_wb` is forced to 0.
- Store: write enable = valid & memwrite & ~mem_misalign & ~stall.
  - Exactly one write per instruction, on the edge where it leaves MEM.
- Load: `mem_rdata` is the combinational array read when valid & memread & ~misalign; otherwise 0.
- memread and memwrite both set: store only; `mem_rdata` returns the pre-write contents.
- `mem_pcsrc` = valid & branch & zero. Misalignment does not affect it.

## Timing
- Instruction in EX in cycle N is captured at the N/N+1 edge. Its MEM outputs are valid throughout cycle N+1.
- Store lands at the N+1/N+2 edge, or later if stalled. A load in cycle N+2 of the same word sees the new data.
- `mem_pcsrc` is asserted in cycle N+1 only. The fetch side squashes IF/ID/EX via `flush` of upstream latches.
- Reset values: every output 0.
- Reset asserted mid-store with write enable high on the same edge: the write is suppressed; reset wins.
- Stall and flush asserted together: flush wins, the bubble is loaded, and the MEM-resident store does not write.
- Latency through the latch: one cycle. No combinational path from `ex_*` to any output.

## Structure
- Shared package `pipe_pkg` holds:
  - control-bundle widths and bit positions: WB_REGWRITE = 1, WB_MEMTOREG = 0, M_BRANCH = 2, M_MEMREAD = 1, M_MEMWRITE = 0;
  - BUBBLE constants for flush;
  - the ALU control codes shared with the EX stage.
- Sub-module `data_mem`: single-port array with synchronous write and asynchronous read, parameterised by DEPTH.
- Latch, misalignment and pcsrc logic live in `mem_stage`.

## Test plan
- Reset, then store 0xDEADBEEF at aluout 0x10, then load 0x10 → `mem_rdata` = 0xDEADBEEF in the load's MEM cycle; `mem_wb` = 2'b11.
- Store at 0x13 → `mem_misalign` = 1, `mem_wb` = 0, `mem_rdata` = 0; a load of 0x10 still returns its old value.
- Branch with zero = 1 → `mem_pcsrc` high exactly one cycle, `mem_npc` = ex_npc. With zero = 0 → `mem_pcsrc` stays low.
- Store 0x1 to 0x20 held by `stall` for 3 cycles, then store 0x2 to 0x20 → exactly one write per store; final word 0x2; the array write enable pulses twice in total.
- Store in EX with flush = 1 and stall = 1 on the same edge → bubble loaded (all outputs 0 next cycle); the MEM-resident store does not write.
- Address 0x400 with DEPTH = 256 → aliases word 0; store then load at 0x0 returns the stored value.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the pipeline stages.
//   - Control-bundle widths and bit positions (WB = {regwrite, memtoreg},
//     M = {branch, memread, memwrite}).
//   - Bubble constants that flush loads into a latch.
//   - ALU control codes shared with the EX stage.
//   - The EX/MEM latch record.
package pipe_pkg;

    localparam int WB_W        = 2;
    localparam int M_W         = 3;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;

    localparam logic [WB_W-1:0] WB_BUBBLE = '0;
    localparam logic [M_W-1:0]  M_BUBBLE  = '0;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctrl_t;

    typedef struct packed {
        logic            valid;
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [31:0]     npc;
        logic [31:0]     aluout;
        logic            zero;
        logic [31:0]     rdata2;
        logic [4:0]      dst;
    } exmem_t;

    // Data fields are zeroed too, so a flushed slot reads as all-zero outputs.
    localparam exmem_t EXMEM_BUBBLE = '{valid: 1'b0, wb: WB_BUBBLE, m: M_BUBBLE,
                                        npc: '0, aluout: '0, zero: 1'b0,
                                        rdata2: '0, dst: '0};

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX-side inputs and MEM-side outputs of the memory stage.
//   ex_*  : values produced by EX, captured into the EX/MEM latch.
//   mem_* : MEM-stage results presented to the MEM/WB latch and fetch.
// master = EX/upstream side (drives ex_*), slave = mem_stage.
interface mem_stage_if;
    import pipe_pkg::*;

    logic [WB_W-1:0] ex_wb;
    logic [M_W-1:0]  ex_m;
    logic [31:0]     ex_npc;
    logic [31:0]     ex_aluout;
    logic            ex_aluzero;
    logic [31:0]     ex_rdata2;
    logic [4:0]      ex_dst;

    logic [WB_W-1:0] mem_wb;
    logic            mem_pcsrc;
    logic [31:0]     mem_npc;
    logic [31:0]     mem_aluout;
    logic [31:0]     mem_rdata;
    logic [4:0]      mem_dst;
    logic            mem_misalign;

    modport master (
        output ex_wb, ex_m, ex_npc, ex_aluout, ex_aluzero, ex_rdata2, ex_dst,
        input  mem_wb, mem_pcsrc, mem_npc, mem_aluout, mem_rdata, mem_dst,
               mem_misalign
    );

    modport slave (
        input  ex_wb, ex_m, ex_npc, ex_aluout, ex_aluzero, ex_rdata2, ex_dst,
        output mem_wb, mem_pcsrc, mem_npc, mem_aluout, mem_rdata, mem_dst,
               mem_misalign
    );
endinterface

// File: rtl/mem_stage_data_mem.sv
// data_mem: single-port word array, synchronous write, asynchronous read.
//   clk     : rising-edge clock
//   we_i    : write enable
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : combinational read of addr_i (pre-write contents this cycle)
// The array has no reset.
module data_mem #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM latch, data memory and branch resolution.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   stall : hold the latch (MEM instruction repeats)
//   flush : load a bubble instead of the EX values
//   bus   : ex_* inputs / mem_* outputs (mem_stage_if.slave)
// All outputs come from the latch; no combinational path from ex_*.
module mem_stage
    import pipe_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    mem_stage_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    exmem_t      ex_mem_q, ex_mem_d;
    logic        access, misalign, we, rd_en;
    logic [31:0] rd_word;

    // Priority below rst: flush beats stall beats a normal load.
    always_comb begin
        ex_mem_d = ex_mem_q;
        if (flush) begin
            ex_mem_d = EXMEM_BUBBLE;
        end else if (!stall) begin
            ex_mem_d.valid  = 1'b1;
            ex_mem_d.wb     = bus.ex_wb;
            ex_mem_d.m      = bus.ex_m;
            ex_mem_d.npc    = bus.ex_npc;
            ex_mem_d.aluout = bus.ex_aluout;
            ex_mem_d.zero   = bus.ex_aluzero;
            ex_mem_d.rdata2 = bus.ex_rdata2;
            ex_mem_d.dst    = bus.ex_dst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ex_mem_q <= '0;
        else     ex_mem_q <= ex_mem_d;
    end

    assign access   = ex_mem_q.valid & (ex_mem_q.m[M_MEMREAD] | ex_mem_q.m[M_MEMWRITE]);
    assign misalign = access & (ex_mem_q.aluout[1:0] != 2'b00);

    // Write on the edge the store leaves MEM: not while stalled (it will
    // repeat), and never on a reset edge.
    assign we    = ex_mem_q.valid & ex_mem_q.m[M_MEMWRITE] & ~misalign & ~stall & ~rst;
    assign rd_en = ex_mem_q.valid & ex_mem_q.m[M_MEMREAD] & ~misalign;

    // Upper address bits are dropped: addresses wrap modulo DEPTH*4.
    data_mem #(.DEPTH(DEPTH)) u_dmem (
        .clk     (clk),
        .we_i    (we),
        .addr_i  (ex_mem_q.aluout[AW+1:2]),
        .wdata_i (ex_mem_q.rdata2),
        .rdata_o (rd_word)
    );

    assign bus.mem_wb       = misalign ? WB_BUBBLE : ex_mem_q.wb;
    assign bus.mem_pcsrc    = ex_mem_q.valid & ex_mem_q.m[M_BRANCH] & ex_mem_q.zero;
    assign bus.mem_npc      = ex_mem_q.npc;
    assign bus.mem_aluout   = ex_mem_q.aluout;
    assign bus.mem_rdata    = rd_en ? rd_word : 32'h0;
    assign bus.mem_dst      = ex_mem_q.dst;
    assign bus.mem_misalign = misalign;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the stimulus pushes the expected MEM-stage
// outputs for the following cycle; a negedge monitor pops and compares.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst, stall, flush;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   we_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_stage_if bus();

    mem_stage #(.DEPTH(256)) dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct packed {
        int          cyc;
        logic [7:0]  tag;
        logic [1:0]  wb;
        logic        pcsrc;
        logic [31:0] npc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  dst;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s tag=%0d got=%h want=%h (cycle %0d)", name, tag, act, exp, cyc);
        end
    endtask

    // Monitor: compare whatever expectation is due this cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (dut.u_dmem.we_i) we_cnt++;
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                total++; bad++;
                $display("FAIL missed_slot tag=%0d got=cycle%0d want=cycle%0d", e.tag, cyc, e.cyc);
            end else begin
                chk("wb",       e.tag, {30'd0, bus.mem_wb},     {30'd0, e.wb});
                chk("pcsrc",    e.tag, {31'd0, bus.mem_pcsrc},  {31'd0, e.pcsrc});
                chk("npc",      e.tag, bus.mem_npc,             e.npc);
                chk("aluout",   e.tag, bus.mem_aluout,          e.alu);
                chk("rdata",    e.tag, bus.mem_rdata,           e.rdata);
                chk("dst",      e.tag, {27'd0, bus.mem_dst},    {27'd0, e.dst});
                chk("misalign", e.tag, {31'd0, bus.mem_misalign}, {31'd0, e.mis});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] npc,
                         input logic [31:0] alu, input logic z, input logic [31:0] rd2,
                         input logic [4:0] dst);
        bus.ex_wb      = wb;
        bus.ex_m       = m;
        bus.ex_npc     = npc;
        bus.ex_aluout  = alu;
        bus.ex_aluzero = z;
        bus.ex_rdata2  = rd2;
        bus.ex_dst     = dst;
    endtask

    task automatic nop();
        issue(2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0);
    endtask

    // Expected outputs during the next cycle.
    task automatic expect_o(input int tag, input logic [1:0] wb, input logic pcsrc,
                            input logic [31:0] npc, input logic [31:0] alu,
                            input logic [31:0] rdata, input logic [4:0] dst, input logic mis);
        exp_t e;
        e.cyc = cyc + 1; e.tag = tag[7:0]; e.wb = wb; e.pcsrc = pcsrc; e.npc = npc;
        e.alu = alu; e.rdata = rdata; e.dst = dst; e.mis = mis;
        sb.push_back(e);
    endtask

    int base;

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        issue(2'b11, 3'b001, 32'h44, 32'h10, 1'b1, 32'h55, 5'd3);
        tick(); tick();
        // reset wins over a pending EX store
        expect_o(1, 2'b00, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
        tick();
        rst = 1'b0;

        // store DEADBEEF @0x10, then load it back
        issue(2'b00, 3'b001, 32'h0, 32'h10, 1'b0, 32'hDEADBEEF, 5'd0);
        expect_o(2, 2'b00, 0, 32'h0, 32'h10, 32'h0, 5'd0, 0); tick();
        issue(2'b11, 3'b010, 32'h0, 32'h10, 1'b0, 32'h0, 5'd5);
        expect_o(3, 2'b11, 0, 32'h0, 32'h10, 32'hDEADBEEF, 5'd5, 0); tick();

        // misaligned store @0x13 and misaligned load @0x12
        issue(2'b11, 3'b001, 32'h0, 32'h13, 1'b0, 32'h12345678, 5'd7);
        expect_o(4, 2'b00, 0, 32'h0, 32'h13, 32'h0, 5'd7, 1); tick();
        issue(2'b11, 3'b010, 32'h0, 32'h12, 1'b0, 32'h0, 5'd6);
        expect_o(5, 2'b00, 0, 32'h0, 32'h12, 32'h0, 5'd6, 1); tick();
        issue(2'b11, 3'b010, 32'h0, 32'h10, 1'b0, 32'h0, 5'd8);
        expect_o(6, 2'b11, 0, 32'h0, 32'h10, 32'hDEADBEEF, 5'd8, 0); tick();

        // read+write together: store only, rdata is pre-write; then load new value
        issue(2'b00, 3'b011, 32'h0, 32'h10, 1'b0, 32'h0BADF00D, 5'd1);
        expect_o(7, 2'b00, 0, 32'h0, 32'h10, 32'hDEADBEEF, 5'd1, 0); tick();
        issue(2'b11, 3'b010, 32'h0, 32'h10, 1'b0, 32'h0, 5'd2);
        expect_o(8, 2'b11, 0, 32'h0, 32'h10, 32'h0BADF00D, 5'd2, 0); tick();

        // branches: taken for one cycle only, not-taken, taken with misalignment
        issue(2'b00, 3'b100, 32'h1000, 32'h0, 1'b1, 32'h0, 5'd0);
        expect_o(9, 2'b00, 1, 32'h1000, 32'h0, 32'h0, 5'd0, 0); tick();
        issue(2'b10, 3'b000, 32'h2000, 32'h4, 1'b0, 32'h0, 5'd4);
        expect_o(10, 2'b10, 0, 32'h2000, 32'h4, 32'h0, 5'd4, 0); tick();
        issue(2'b00, 3'b100, 32'h3000, 32'h8, 1'b0, 32'h0, 5'd0);
        expect_o(11, 2'b00, 0, 32'h3000, 32'h8, 32'h0, 5'd0, 0); tick();
        issue(2'b01, 3'b110, 32'h3004, 32'h2, 1'b1, 32'h0, 5'd9);
        expect_o(12, 2'b00, 1, 32'h3004, 32'h2, 32'h0, 5'd9, 1); tick();

        // store 1 @0x20 held by stall 3 cycles, then store 2 @0x20, then load
        base = we_cnt;
        issue(2'b00, 3'b001, 32'h0, 32'h20, 1'b0, 32'h1, 5'd9);
        expect_o(13, 2'b00, 0, 32'h0, 32'h20, 32'h0, 5'd9, 0); tick();
        issue(2'b00, 3'b001, 32'h0, 32'h20, 1'b0, 32'h2, 5'd10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_o(14, 2'b00, 0, 32'h0, 32'h20, 32'h0, 5'd9, 0); tick();
        end
        stall = 1'b0;
        expect_o(15, 2'b00, 0, 32'h0, 32'h20, 32'h0, 5'd10, 0); tick();
        issue(2'b11, 3'b010, 32'h0, 32'h20, 1'b0, 32'h0, 5'd11);
        expect_o(16, 2'b11, 0, 32'h0, 32'h20, 32'h2, 5'd11, 0); tick();
        nop(); tick(); tick();
        chk("we_pulses", 17, we_cnt - base, 32'd2);

        // flush+stall: bubble loaded, MEM-resident store dropped
        issue(2'b00, 3'b001, 32'h0, 32'h30, 1'b0, 32'h77, 5'd0);
        expect_o(18, 2'b00, 0, 32'h0, 32'h30, 32'h0, 5'd0, 0); tick();
        issue(2'b00, 3'b001, 32'h0, 32'h30, 1'b0, 32'hAAAA, 5'd0);
        expect_o(19, 2'b00, 0, 32'h0, 32'h30, 32'h0, 5'd0, 0); tick();
        issue(2'b11, 3'b101, 32'h99, 32'h30, 1'b1, 32'hBBBB, 5'd12);
        stall = 1'b1; flush = 1'b1;
        expect_o(20, 2'b00, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0); tick();
        stall = 1'b0; flush = 1'b0;
        issue(2'b11, 3'b010, 32'h0, 32'h30, 1'b0, 32'h0, 5'd13);
        expect_o(21, 2'b11, 0, 32'h0, 32'h30, 32'h77, 5'd13, 0); tick();

        // 0x400 aliases word 0
        issue(2'b00, 3'b001, 32'h0, 32'h400, 1'b0, 32'hCAFEF00D, 5'd0);
        expect_o(22, 2'b00, 0, 32'h0, 32'h400, 32'h0, 5'd0, 0); tick();
        issue(2'b11, 3'b010, 32'h0, 32'h0, 1'b0, 32'h0, 5'd14);
        expect_o(23, 2'b11, 0, 32'h0, 32'h0, 32'hCAFEF00D, 5'd14, 0); tick();

        // reset on the edge a store would write: write suppressed
        issue(2'b00, 3'b001, 32'h0, 32'h40, 1'b0, 32'h1111, 5'd0);
        expect_o(24, 2'b00, 0, 32'h0, 32'h40, 32'h0, 5'd0, 0); tick();
        issue(2'b00, 3'b001, 32'h0, 32'h40, 1'b0, 32'h5555, 5'd0);
        expect_o(25, 2'b00, 0, 32'h0, 32'h40, 32'h0, 5'd0, 0); tick();
        rst = 1'b1;
        issue(2'b11, 3'b111, 32'h7, 32'h44, 1'b1, 32'h9, 5'd15);
        expect_o(26, 2'b00, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0); tick();
        rst = 1'b0;
        issue(2'b11, 3'b010, 32'h0, 32'h40, 1'b0, 32'h0, 5'd16);
        expect_o(27, 2'b11, 0, 32'h0, 32'h40, 32'h1111, 5'd16, 0); tick();

        nop(); tick(); tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d want=0 pending", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
